fpu_issue_ctrl: RTL and testbench

- Issue/writeback scheduler between one instruction requester (core decode stage) and the multi-latency FPU datapath (opcode, x1, x2 in; y, ovf, out_valid out).
- Accepts operations over a valid/ready handshake and drives the FPU inputs.
- Stalls issue when an operation's result would land on the single writeback port in the same cycle as an earlier result, and when the unpipelined divider/sqrt unit is busy.
- Tags returning results with the requester's destination tag and flags any protocol mismatch with the FPU.

---
 rtl/fpu_pkg.sv | 42 ++++
 rtl/fpu_wb_scoreboard.sv | 63 ++++++
 rtl/fpu_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode encodings, operation classes and the
// opcode-to-class decode used by the issue controller.
package fpu_pkg;

    localparam int unsigned OPC_W = 8;

    localparam logic [OPC_W-1:0] OP_FADD  = 8'h10;
    localparam logic [OPC_W-1:0] OP_FSUB  = 8'h11;
    localparam logic [OPC_W-1:0] OP_FMUL  = 8'h12;
    localparam logic [OPC_W-1:0] OP_FDIV  = 8'h13;
    localparam logic [OPC_W-1:0] OP_FSQRT = 8'h14;
    localparam logic [OPC_W-1:0] OP_FNEG  = 8'h15;
    localparam logic [OPC_W-1:0] OP_FABS  = 8'h16;
    localparam logic [OPC_W-1:0] OP_FLT   = 8'h17;
    localparam logic [OPC_W-1:0] OP_FEQ   = 8'h18;
    localparam logic [OPC_W-1:0] OP_ITOF  = 8'h19;
    localparam logic [OPC_W-1:0] OP_FTOI  = 8'h1A;

    // Latency class of an operation; CLS_ILL marks an unknown opcode.
    typedef enum logic [2:0] {
        CLS_ADD,
        CLS_MUL,
        CLS_DIV,
        CLS_MISC,
        CLS_ILL
    } op_class_e;

    // Decode an opcode into its latency class.
    function automatic op_class_e op_class(input logic [OPC_W-1:0] opcode);
        op_class_e cls;
        case (opcode)
            OP_FADD, OP_FSUB:                   cls = CLS_ADD;
            OP_FMUL:                            cls = CLS_MUL;
            OP_FDIV, OP_FSQRT:                  cls = CLS_DIV;
            OP_FNEG, OP_FABS, OP_FLT, OP_FEQ,
            OP_ITOF, OP_FTOI:                   cls = CLS_MISC;
            default:                            cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fpu_wb_scoreboard.sv
// Writeback-slot scoreboard: one bit per future cycle marking an expected
// FPU result, with a parallel tag pipe. Slot 0 is the current cycle.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   ins_en/idx/tag  reserve slot idx (post-shift position) with tag
//   query_idx       slot to test, in pre-shift (current) coordinates
//   slot_free_c     queried slot is empty
//   head_resv       a result is expected this cycle
//   head_tag        tag of the result expected this cycle
//   any_next_c      any slot will be reserved after this clock edge
module fpu_wb_scoreboard #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned DEPTH = 10,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ins_en,
    input  logic [IDX_W-1:0] ins_idx,
    input  logic [TAG_W-1:0] ins_tag,
    input  logic [IDX_W-1:0] query_idx,
    output logic             slot_free_c,
    output logic             head_resv,
    output logic [TAG_W-1:0] head_tag,
    output logic             any_next_c
);

    logic [DEPTH-1:0] slots_q;
    logic [DEPTH-1:0] slots_d;
    logic [TAG_W-1:0] tags_q [DEPTH];
    logic [TAG_W-1:0] tags_d [DEPTH];

    // Advance one cycle, then drop in the new reservation.
    always_comb begin
        slots_d = {1'b0, slots_q[DEPTH-1:1]};
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            tags_d[i] = tags_q[i+1];
        end
        tags_d[DEPTH-1] = '0;
        if (ins_en) begin
            slots_d[ins_idx] = 1'b1;
            tags_d[ins_idx]  = ins_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tags_q[i] <= '0;
            end
        end else begin
            slots_q <= slots_d;
            tags_q  <= tags_d;
        end
    end

    assign slot_free_c = ~slots_q[query_idx];
    assign head_resv   = slots_q[0];
    assign head_tag    = tags_q[0];
    assign any_next_c  = |slots_d;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback scheduler in front of a multi-latency FPU. Accepts ops
// over valid/ready, stalls on writeback-port collisions and on the
// unpipelined divider, tags returning results and flags FPU protocol errors.
// Ports:
//   sys_clk, rst_n                       clock, async active-low reset
//   req_valid/ready/opcode/x1/x2/tag     requester handshake and op
//   fpu_in_valid/opcode/x1/x2            registered issue to the FPU
//   fpu_y/ovf/out_valid                  FPU result
//   wb_valid/tag/data/ovf                registered tagged writeback
//   ill_op                               pulse: illegal opcode consumed
//   busy                                 any op in flight
//   err                                  sticky result/reservation mismatch
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_DIV  = 8,
    parameter int unsigned LAT_MISC = 1,
    parameter int unsigned MAX_LAT  = 8
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_opcode,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             fpu_in_valid,
    output logic [7:0]       fpu_opcode,
    output logic [31:0]      fpu_x1,
    output logic [31:0]      fpu_x2,
    input  logic [31:0]      fpu_y,
    input  logic             fpu_ovf,
    input  logic             fpu_out_valid,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             wb_ovf,
    output logic             ill_op,
    output logic             busy,
    output logic             err
);

    localparam int unsigned DEPTH = MAX_LAT + 2;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LAT_DIV + 1);

    op_class_e        req_cls;
    logic             is_ill;
    logic             is_div;
    logic [IDX_W-1:0] lat_c;
    logic [IDX_W-1:0] query_idx;
    logic             slot_free_c;
    logic             head_resv;
    logic [TAG_W-1:0] head_tag;
    logic             any_next_c;
    logic             ready_en;
    logic             div_block;
    logic             accept;
    logic             issue;
    logic             retire;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_next;

    assign req_cls = op_class(req_opcode);
    assign is_ill  = (req_cls == CLS_ILL);
    assign is_div  = (req_cls == CLS_DIV);

    // Cycles from issue to the FPU raising out_valid for this op.
    always_comb begin
        lat_c = '0;
        case (req_cls)
            CLS_ADD:  lat_c = IDX_W'(LAT_ADD);
            CLS_MUL:  lat_c = IDX_W'(LAT_MUL);
            CLS_DIV:  lat_c = IDX_W'(LAT_DIV);
            CLS_MISC: lat_c = IDX_W'(LAT_MISC);
            default:  lat_c = '0;
        endcase
    end

    // Result lands 1+LAT cycles after acceptance; check that slot before the shift.
    assign query_idx = lat_c + IDX_W'(1);

    // ready_en keeps req_ready low while in reset and for the first edge after.
    assign div_block = is_div & (div_cnt != '0);
    assign req_ready = ready_en & (is_ill | (slot_free_c & ~div_block));
    assign accept    = req_valid & req_ready;
    assign issue     = accept & ~is_ill;
    assign retire    = fpu_out_valid & head_resv;

    // Divider occupancy countdown.
    always_comb begin
        div_cnt_next = div_cnt;
        if (issue && is_div) begin
            div_cnt_next = CNT_W'(LAT_DIV);
        end else if (div_cnt != '0) begin
            div_cnt_next = div_cnt - CNT_W'(1);
        end
    end

    fpu_wb_scoreboard #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_sb (
        .clk         (sys_clk),
        .rst_n       (rst_n),
        .ins_en      (issue),
        .ins_idx     (lat_c),
        .ins_tag     (req_tag),
        .query_idx   (query_idx),
        .slot_free_c (slot_free_c),
        .head_resv   (head_resv),
        .head_tag    (head_tag),
        .any_next_c  (any_next_c)
    );

    // Issue, writeback and status registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en     <= 1'b0;
            fpu_in_valid <= 1'b0;
            fpu_opcode   <= '0;
            fpu_x1       <= '0;
            fpu_x2       <= '0;
            ill_op       <= 1'b0;
            div_cnt      <= '0;
            wb_valid     <= 1'b0;
            wb_tag       <= '0;
            wb_data      <= '0;
            wb_ovf       <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            ready_en     <= 1'b1;
            fpu_in_valid <= issue;
            if (issue) begin
                fpu_opcode <= req_opcode;
                fpu_x1     <= req_x1;
                fpu_x2     <= req_x2;
            end
            ill_op   <= accept & is_ill;
            div_cnt  <= div_cnt_next;
            wb_valid <= retire;
            if (retire) begin
                wb_tag  <= head_tag;
                wb_data <= fpu_y;
                wb_ovf  <= fpu_ovf;
            end
            busy <= any_next_c | (div_cnt_next != '0);
            // Any result without a reservation, or a reservation without a result.
            err  <= err | (fpu_out_valid ^ head_resv);
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl with a behavioural FPU and an
// expected-writeback scoreboard keyed by the cycle each result must retire.
module tb_fpu_issue_ctrl;

    localparam int unsigned TAG_W = 5;

    localparam logic [7:0] OP_FADD  = 8'h10;
    localparam logic [7:0] OP_FMUL  = 8'h12;
    localparam logic [7:0] OP_FDIV  = 8'h13;
    localparam logic [7:0] OP_FSQRT = 8'h14;
    localparam logic [7:0] OP_FNEG  = 8'h15;
    localparam logic [7:0] OP_FTOI  = 8'h1A;

    logic             sys_clk = 1'b0;
    logic             rst_n   = 1'b1;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_opcode;
    logic [31:0]      req_x1;
    logic [31:0]      req_x2;
    logic [TAG_W-1:0] req_tag;
    logic             fpu_in_valid;
    logic [7:0]       fpu_opcode;
    logic [31:0]      fpu_x1;
    logic [31:0]      fpu_x2;
    logic [31:0]      fpu_y = '0;
    logic             fpu_ovf = 1'b0;
    logic             fpu_out_valid = 1'b0;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_ovf;
    logic             ill_op;
    logic             busy;
    logic             err;

    typedef struct {
        int               cyc;
        logic [TAG_W-1:0] tag;
        logic [31:0]      y;
        logic             ovf;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] y;
        logic        ovf;
    } fpu_t;

    exp_t exp_q[$];
    fpu_t fpu_q[$];
    int   cyc         = 0;
    int   n_checks    = 0;
    int   n_pass      = 0;
    int   inject_cyc  = -1;
    bit   expect_busy = 1'b0;

    fpu_issue_ctrl #(
        .TAG_W    (TAG_W),
        .LAT_ADD  (3),
        .LAT_MUL  (2),
        .LAT_DIV  (8),
        .LAT_MISC (1),
        .MAX_LAT  (8)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_x1        (req_x1),
        .req_x2        (req_x2),
        .req_tag       (req_tag),
        .fpu_in_valid  (fpu_in_valid),
        .fpu_opcode    (fpu_opcode),
        .fpu_x1        (fpu_x1),
        .fpu_x2        (fpu_x2),
        .fpu_y         (fpu_y),
        .fpu_ovf       (fpu_ovf),
        .fpu_out_valid (fpu_out_valid),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_data       (wb_data),
        .wb_ovf        (wb_ovf),
        .ill_op        (ill_op),
        .busy          (busy),
        .err           (err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int tb_lat(input logic [7:0] op);
        case (op)
            8'h10, 8'h11:                      return 3;
            8'h12:                             return 2;
            8'h13, 8'h14:                      return 8;
            8'h15, 8'h16, 8'h17, 8'h18,
            8'h19, 8'h1A:                      return 1;
            default:                           return -1;
        endcase
    endfunction

    function automatic logic [31:0] model_y(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        return (a + b) ^ {24'h0, op};
    endfunction

    function automatic logic model_ovf(input logic [31:0] a, input logic [31:0] b);
        return (^a[31:28]) ^ b[0];
    endfunction

    // Behavioural FPU plus writeback scoreboard check, evaluated mid-cycle.
    always @(negedge sys_clk) begin
        int   idx;
        fpu_t f;
        idx = -1;
        if (rst_n) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].cyc == cyc) begin
                    idx = i;
                    break;
                end
            end
            if (idx >= 0) begin
                check("wb_valid", 64'(wb_valid), 64'(1));
                if (wb_valid) begin
                    check("wb_tag", 64'(wb_tag), 64'(exp_q[idx].tag));
                    check("wb_data", 64'(wb_data), 64'(exp_q[idx].y));
                    check("wb_ovf", 64'(wb_ovf), 64'(exp_q[idx].ovf));
                end
                exp_q.delete(idx);
            end else if (wb_valid) begin
                check("wb_unexpected", 64'(wb_valid), 64'(0));
            end
            if (expect_busy) check("busy_div", 64'(busy), 64'(1));
            if (fpu_in_valid) begin
                f.due = cyc + tb_lat(fpu_opcode);
                f.y   = model_y(fpu_opcode, fpu_x1, fpu_x2);
                f.ovf = model_ovf(fpu_x1, fpu_x2);
                fpu_q.push_back(f);
            end
        end
        fpu_out_valid = (cyc == inject_cyc);
        fpu_y         = '0;
        fpu_ovf       = 1'b0;
        for (int i = 0; i < fpu_q.size(); i++) begin
            if (fpu_q[i].due == cyc) begin
                fpu_out_valid = 1'b1;
                fpu_y         = fpu_q[i].y;
                fpu_ovf       = fpu_q[i].ovf;
                fpu_q.delete(i);
                break;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Offer one op from a negedge until accepted; returns the stall count.
    task automatic send(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tg, output int stalls);
        exp_t e;
        stalls     = 0;
        req_valid  = 1'b1;
        req_opcode = op;
        req_x1     = a;
        req_x2     = b;
        req_tag    = tg;
        #1;
        while (!req_ready && stalls < 40) begin
            @(negedge sys_clk);
            #1;
            stalls++;
        end
        check("send_ready", 64'(req_ready), 64'(1));
        if (req_ready && tb_lat(op) >= 0) begin
            e.cyc = cyc + 2 + tb_lat(op);
            e.tag = tg;
            e.y   = model_y(op, a, b);
            e.ovf = model_ovf(a, b);
            exp_q.push_back(e);
        end
        @(negedge sys_clk);
        req_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        fpu_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_x1     = '0;
        req_x2     = '0;
        req_tag    = '0;
        rst_n      = 1'b0;

        // Reset values.
        repeat (3) @(negedge sys_clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_fpu_in_valid", 64'(fpu_in_valid), 64'(0));
        check("rst_fpu_opcode", 64'(fpu_opcode), 64'(0));
        check("rst_fpu_x1", 64'(fpu_x1), 64'(0));
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_wb_tag", 64'(wb_tag), 64'(0));
        check("rst_wb_data", 64'(wb_data), 64'(0));
        check("rst_ill_op", 64'(ill_op), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("ready_after_rst", 64'(req_ready), 64'(1));

        // Back-to-back adds.
        send(OP_FADD, 32'h44fa21b3, 32'h44fa40f8, 5'd1, st);
        check("b2b_stall0", 64'(st), 64'(0));
        send(OP_FADD, 32'h43fa3146, 32'h45fa4345, 5'd2, st);
        check("b2b_stall1", 64'(st), 64'(0));
        check("busy_after_add", 64'(busy), 64'(1));
        idle(12);

        // Add then mul collide on the writeback port.
        send(OP_FADD, 32'h3f800000, 32'h40000000, 5'd3, st);
        send(OP_FMUL, 32'h40400000, 32'h40800000, 5'd4, st);
        check("collide_stall", 64'(st), 64'(1));
        idle(12);

        // Short op overtakes a long one; retirement in completion order.
        send(OP_FADD, 32'h12345678, 32'h0badf00d, 5'd8, st);
        send(OP_FNEG, 32'hc0000000, 32'h00000001, 5'd9, st);
        check("ooo_stall", 64'(st), 64'(0));
        send(OP_FTOI, 32'h41200000, 32'h0, 5'd20, st);
        idle(12);

        // Divider occupancy.
        send(OP_FDIV, 32'h3fd61587, 32'hbf561e83, 5'd10, st);
        expect_busy = 1'b1;
        send(OP_FSQRT, 32'h3fd61587, 32'h00000000, 5'd11, st);
        expect_busy = 1'b0;
        check("div_stall", 64'(st), 64'(8));
        check("busy_sqrt", 64'(busy), 64'(1));
        idle(14);
        check("busy_drained", 64'(busy), 64'(0));

        // Illegal opcode.
        send(8'hFF, 32'h1, 32'h2, 5'd7, st);
        check("ill_stall", 64'(st), 64'(0));
        check("ill_pulse", 64'(ill_op), 64'(1));
        check("ill_no_issue", 64'(fpu_in_valid), 64'(0));
        @(negedge sys_clk);
        check("ill_clear", 64'(ill_op), 64'(0));
        check("ill_no_issue2", 64'(fpu_in_valid), 64'(0));
        check("ill_not_busy", 64'(busy), 64'(0));

        // Illegal opcode still accepted while the divider is busy.
        send(OP_FDIV, 32'h40490fdb, 32'h3f800000, 5'd12, st);
        send(8'hAB, 32'h0, 32'h0, 5'd13, st);
        check("ill_during_div", 64'(st), 64'(0));
        idle(14);

        // Unreserved result sets the sticky error.
        check("err_pre", 64'(err), 64'(0));
        inject_cyc = cyc + 2;
        idle(3);
        check("err_set", 64'(err), 64'(1));
        idle(4);
        check("err_sticky", 64'(err), 64'(1));
        pulse_reset();
        check("err_cleared", 64'(err), 64'(0));
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // Reset in the middle of a divide.
        send(OP_FDIV, 32'h3fd61587, 32'hbf561e83, 5'd14, st);
        idle(2);
        check("busy_mid_div", 64'(busy), 64'(1));
        pulse_reset();
        check("rst_mid_busy", 64'(busy), 64'(0));
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        req_opcode = OP_FDIV;
        #1;
        check("div_cnt_cleared", 64'(req_ready), 64'(1));
        @(negedge sys_clk);
        send(OP_FDIV, 32'h40000000, 32'h3f000000, 5'd15, st);
        check("div_after_rst", 64'(st), 64'(0));
        idle(14);

        check("sb_drain", 64'(exp_q.size()), 64'(0));
        check("final_err", 64'(err), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
